// File: rtl/yarp_pkg.sv
// Shared types and constants for the YARP data-memory responder:
// access-size encodings, timer register offsets and byte-lane helpers.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_access_size_t;

  localparam logic [3:0] MTIME_LO    = 4'h0;
  localparam logic [3:0] MTIME_HI    = 4'h4;
  localparam logic [3:0] MTIMECMP_LO = 4'h8;
  localparam logic [3:0] MTIMECMP_HI = 4'hC;

  // Lanes touched by a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      BYTE:      mask = 4'b0001 << addr_lo;
      HALF_WORD: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      WORD:      mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Store data arrives right-justified; replicate it so every candidate lane sees it.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      BYTE:      lanes = {4{data[7:0]}};
      HALF_WORD: lanes = {2{data[15:0]}};
      default:   lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/yarp_mtimer.sv
// Machine timer: free-running 64-bit mtime, mtimecmp, a hi-half shadow for
// atomic lo-then-hi reads, and a registered compare interrupt.
module yarp_mtimer import yarp_pkg::*; (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en_i,
  input  logic        rd_lo_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        timer_irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        irq_q, irq_d;

  // Next-state: a store to an mtime half overrides the increment for that cycle.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    if (wr_en_i) begin
      case ({sel_i, 2'b00})
        MTIME_LO:    mtime_d    = {mtime_q[63:32], wdata_i};
        MTIME_HI:    mtime_d    = {wdata_i, mtime_q[31:0]};
        MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
        MTIMECMP_HI: mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
        default:     mtime_d    = mtime_q + 64'd1;
      endcase
    end else if (rd_lo_i) begin
      shadow_d = mtime_q[63:32];
    end else begin
      shadow_d = shadow_q;
    end
    irq_d = (mtime_q >= mtimecmp_q);
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q   <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      irq_q      <= irq_d;
    end
  end

  // Register read mux; mtime_hi comes from the shadow, not the live counter.
  always_comb begin
    case ({sel_i, 2'b00})
      MTIME_LO:    rdata_o = mtime_q[31:0];
      MTIME_HI:    rdata_o = shadow_q;
      MTIMECMP_LO: rdata_o = mtimecmp_q[31:0];
      MTIMECMP_HI: rdata_o = mtimecmp_q[63:32];
      default:     rdata_o = 32'h0;
    endcase
  end

  assign timer_irq_o = irq_q;

endmodule

// File: rtl/yarp_data_mem_resp.sv
// Responder for the YARP core data-memory port: address decode, legality,
// word RAM with byte-lane stores, the machine timer and the error pulse.
module yarp_data_mem_resp import yarp_pkg::*; #(
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] TIMER_BASE = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  output logic        err_o,
  output logic        timer_irq_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   ram_off_s;
  logic [AW-1:0] ram_idx_s;
  logic          ram_hit_s, tmr_hit_s, align_ok_s, legal_s, acc_s;
  logic          ram_we_s, tmr_we_s, tmr_rd_lo_s;
  logic [3:0]    wmask_s;
  logic [31:0]   wlane_s, tmr_rdata_s;
  logic          err_q, err_d;

  // Decode, legality and strobes for the current request.
  always_comb begin
    ram_off_s = data_mem_addr_i - RAM_BASE;
    ram_hit_s = (ram_off_s < RAM_BYTES);
    ram_idx_s = ram_off_s[AW+1:2];
    tmr_hit_s = (data_mem_addr_i[31:4] == TIMER_BASE[31:4]);
    case (data_mem_byte_en_i)
      BYTE:      align_ok_s = 1'b1;
      HALF_WORD: align_ok_s = ~data_mem_addr_i[0];
      WORD:      align_ok_s = (data_mem_addr_i[1:0] == 2'b00);
      default:   align_ok_s = 1'b0;
    endcase
    if (ram_hit_s) begin
      legal_s = align_ok_s;
    end else if (tmr_hit_s) begin
      legal_s = align_ok_s && (data_mem_byte_en_i == WORD);
    end else begin
      legal_s = 1'b0;
    end
    acc_s       = data_mem_req_i && legal_s;
    ram_we_s    = acc_s && data_mem_wr_i && ram_hit_s;
    tmr_we_s    = acc_s && data_mem_wr_i && tmr_hit_s;
    tmr_rd_lo_s = acc_s && !data_mem_wr_i && tmr_hit_s && (data_mem_addr_i[3:2] == 2'b00);
    wmask_s     = lane_mask(data_mem_byte_en_i, data_mem_addr_i[1:0]);
    wlane_s     = lane_data(data_mem_byte_en_i, data_mem_wr_data_i);
    err_d       = data_mem_req_i && !legal_s;
  end

  // Zero-latency read data; anything other than a legal load returns zero.
  always_comb begin
    if (acc_s && !data_mem_wr_i) begin
      data_mem_rd_data_o = ram_hit_s ? mem_q[ram_idx_s] : tmr_rdata_s;
    end else begin
      data_mem_rd_data_o = 32'h0;
    end
  end

  // RAM contents survive reset; reset only suppresses a write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ram_we_s && wmask_s[i]) begin
          mem_q[ram_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
        end
      end
    end
  end

  // One-cycle error pulse following an illegal request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

  yarp_mtimer u_mtimer (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en_i     (tmr_we_s),
    .rd_lo_i     (tmr_rd_lo_s),
    .sel_i       (data_mem_addr_i[3:2]),
    .wdata_i     (data_mem_wr_data_i),
    .rdata_o     (tmr_rdata_s),
    .timer_irq_o (timer_irq_o)
  );

endmodule

// File: tb/tb_yarp_data_mem_resp.sv
// Directed self-checking bench for yarp_data_mem_resp.
module tb_yarp_data_mem_resp;

  localparam logic [31:0] TB = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic [1:0]  be;
  logic [31:0] rd_data;
  logic        err_o, irq_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;

  yarp_data_mem_resp dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .data_mem_req_i     (req),
    .data_mem_addr_i    (addr),
    .data_mem_byte_en_i (be),
    .data_mem_wr_i      (wr),
    .data_mem_wr_data_i (wdata),
    .data_mem_rd_data_o (rd_data),
    .err_o              (err_o),
    .timer_irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    req = 1'b0; wr = 1'b0; be = 2'b00; addr = 32'h0; wdata = 32'h0;
    @(posedge clk); #1;
  endtask

  // Drive one request for one cycle: rd is sampled before the edge, er after it.
  task automatic op(input logic w, input logic [1:0] b, input logic [31:0] a,
                    input logic [31:0] d, output logic [31:0] r, output logic e);
    req = 1'b1; wr = w; be = b; addr = a; wdata = d;
    #1; r = rd_data;
    @(posedge clk); #1;
    e = err_o;
    req = 1'b0; wr = 1'b0; be = 2'b00; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 1'b0; wr = 1'b0; be = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    reset_n = 1'b1;
    #1;
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd_data); end
    @(posedge clk); #1;
    op(1'b0, 2'b11, TB + 32'h8, 32'h0, rd, er);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mtimecmp_lo: got %h want ffffffff", rd); end
  endtask

  task automatic test_word_rw();
    op(1'b1, 2'b11, 32'h10, 32'hDEAD_BEEF, rd, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_store_err: got %b want 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL word_store_rd: got %h want 0", rd); end
    op(1'b0, 2'b11, 32'h10, 32'h0, rd, er);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_load_err: got %b want 0", er); end
  endtask

  task automatic test_byte_merge();
    op(1'b1, 2'b00, 32'h12, 32'h0000_0055, rd, er);
    op(1'b1, 2'b01, 32'h10, 32'h0000_1234, rd, er);
    op(1'b0, 2'b11, 32'h10, 32'h0, rd, er);
    checks++; if (rd !== 32'hDE55_1234) begin errors++; $display("FAIL byte_merge: got %h want de551234", rd); end
    op(1'b0, 2'b00, 32'h13, 32'h0, rd, er);
    checks++; if (rd !== 32'hDE55_1234) begin errors++; $display("FAIL byte_load_word: got %h want de551234", rd); end
    op(1'b1, 2'b01, 32'h1A, 32'hFFFF_ABCD, rd, er);
    op(1'b0, 2'b11, 32'h18, 32'h0, rd, er);
    checks++; if (rd[31:16] !== 16'hABCD) begin errors++; $display("FAIL half_upper: got %h want abcd", rd[31:16]); end
  endtask

  task automatic test_illegal();
    logic [31:0] a_tab [4] = '{32'h11, 32'h12, 32'h0, 32'h0100_0000};
    logic [1:0]  b_tab [4] = '{2'b01, 2'b11, 2'b10, 2'b11};
    logic        w_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      op(w_tab[i], b_tab[i], a_tab[i], 32'hBBBB_BBBB, rd, er);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL illegal_rd[%0d]: got %h want 0", i, rd); end
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL illegal_err[%0d]: got %b want 1", i, er); end
      idle();
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse[%0d]: got %b want 0", i, err_o); end
    end
    op(1'b0, 2'b11, 32'h10, 32'h0, rd, er);
    checks++; if (rd !== 32'hDE55_1234) begin errors++; $display("FAIL illegal_no_write: got %h want de551234", rd); end
  endtask

  task automatic test_timer_roll();
    op(1'b1, 2'b11, TB + 32'h4, 32'h0, rd, er);
    op(1'b1, 2'b11, TB + 32'h0, 32'hFFFF_FFFE, rd, er);
    repeat (3) idle();
    op(1'b0, 2'b11, TB + 32'h0, 32'h0, rd, er);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL roll_lo: got %h want 00000001", rd); end
    op(1'b0, 2'b11, TB + 32'h4, 32'h0, rd, er);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL roll_hi: got %h want 00000001", rd); end
    op(1'b0, 2'b00, TB, 32'h0, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL timer_byte_err: got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL timer_byte_rd: got %h want 0", rd); end
  endtask

  task automatic test_irq();
    op(1'b1, 2'b11, TB + 32'h4, 32'h0, rd, er);
    op(1'b1, 2'b11, TB + 32'h0, 32'h0, rd, er);
    op(1'b1, 2'b11, TB + 32'hC, 32'h0, rd, er);
    op(1'b1, 2'b11, TB + 32'h8, 32'd20, rd, er);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq_o); end
    repeat (18) idle();
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_at_20: got %b want 0", irq_o); end
    op(1'b0, 2'b11, TB + 32'h0, 32'h0, rd, er);
    checks++; if (rd !== 32'd20) begin errors++; $display("FAIL irq_mtime: got %0d want 20", rd); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq_o); end
    op(1'b1, 2'b11, TB + 32'hC, 32'hFFFF_FFFF, rd, er);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b want 1", irq_o); end
    idle();
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", irq_o); end
  endtask

  task automatic test_async_reset();
    op(1'b1, 2'b11, 32'h20, 32'hCAFE_F00D, rd, er);
    op(1'b1, 2'b11, TB + 32'hC, 32'h0, rd, er);
    op(1'b0, 2'b10, 32'h0, 32'h0, rd, er);
    checks++; if (irq_o !== 1'b1 || err_o !== 1'b1) begin errors++; $display("FAIL pre_reset: got irq=%b err=%b want 1 1", irq_o, err_o); end
    req = 1'b1; wr = 1'b1; be = 2'b11; addr = 32'h20; wdata = 32'h1111_1111;
    #2; reset_n = 1'b0;
    #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL async_irq: got %b want 0", irq_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL async_err: got %b want 0", err_o); end
    @(posedge clk); #2;
    req = 1'b0; wr = 1'b0; be = 2'b00; addr = 32'h0; wdata = 32'h0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    op(1'b0, 2'b11, TB + 32'h0, 32'h0, rd, er);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL post_reset_mtime: got %h want 1", rd); end
    op(1'b0, 2'b11, 32'h20, 32'h0, rd, er);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL reset_drop_store: got %h want cafef00d", rd); end
    op(1'b0, 2'b11, TB + 32'hC, 32'h0, rd, er);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL post_reset_cmp: got %h want ffffffff", rd); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_merge();
    test_illegal();
    test_timer_roll();
    test_irq();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
